alu_ctrl_unit: RTL and testbench
================================

// Module: alu_ctrl_unit
// PURPOSE
//  Next-generation ALU control for the ARMv4 datapath. Decodes data-processing cmd/S into a
//  3-bit ALUControl covering all logical/compare ops, holds the NZCV flag register and
//  evaluates the condition field. An optional pipeline register sits between decode and
//  condition/flag-write. Replaces the 2-bit single-cycle decoder + external flag logic.
// PARAMETERS
//  PIPE     1  0: decode combinational to outputs; 1: decode registered one cycle (execute stage)
//  EXT_OPS  1  1: EOR/BIC/MOV/MVN/TST/TEQ/CMP/CMN legal; 0: only ADD/SUB/AND/ORR legal
// PORTS
//  clk       in   1  rising-edge clock, single domain
//  reset     in   1  synchronous, active-high
//  en        in   1  stage enable; 0 = stall (stage reg and flags hold)
//  flush     in   1  load bubble into stage reg (PIPE=1); ignored when PIPE=0
//  valid_i   in   1  instruction present on ALUOp/Funct/Cond
//  ALUOp     in   1  1 = data-processing instruction
//  Funct     in   5  {cmd[3:0], S}
//  Cond      in   4  ARM condition field
//  ALUFlags  in   4  {N,Z,C,V} from ALU for the op currently at outputs
//  ALUControl out 3  000 ADD,001 SUB,010 AND,011 ORR,100 EOR,101 BIC,110 MOV,111 MVN
//  FlagW     out  2  [1]=NZ write, [0]=CV write (raw decode, not gated by CondEx)
//  NoWrite   out  1  suppress Rd writeback (compare/test ops, illegal)
//  CondEx    out  1  valid & condition true on stored flags
//  Illegal   out  1  valid & undecodable op
//  Flags     out  4  stored {N,Z,C,V}
// BEHAVIOUR
//  Reset: Flags=0000; stage reg = bubble; all outputs 0 (ALUControl=000).
//  Decode (ALUOp=1): ADD 0100, SUB 0010 -> FlagW=S?11:00. AND 0000, ORR 1100, EOR 0001,
//   BIC 1110, MOV 1101, MVN 1111 -> FlagW=S?10:00. CMP 1010->SUB, CMN 1011->ADD: FlagW=11;
//   TST 1000->AND, TEQ 1001->EOR: FlagW=10; all four NoWrite=1.
//  Compare/test with S=0, cmd RSB/ADC/SBC/RSC, or EXT_OPS=0 extended op: Illegal=1,
//   ALUControl=000, FlagW=00, NoWrite=1.
//  ALUOp=0 (mem/branch): ALUControl=000 (ADD), FlagW=00, NoWrite=0, Illegal=0.
//  Condition on stored Flags: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE per ARM;
//   1110 AL and 1111 -> true. CondEx = stage_valid & cond_true.
//  PIPE=0: stage signals = inputs directly; latency 0. PIPE=1: on en & ~flush, stage reg <=
//   {valid_i, decode, Cond}; latency 1 cycle. flush (any en) -> stage_valid=0, FlagW=00.
//   flush wins over en=0.
//  Flag write at posedge when en & CondEx: FlagW[1] -> N,Z <= ALUFlags[3:2];
//   FlagW[0] -> C,V <= ALUFlags[1:0]. Bubble/invalid/illegal never write.
//  No bypass: flags written at edge k are seen by CondEx from cycle k+1 on.
//  en=0: Flags and stage hold; outputs stay stable (combinational from held state/inputs).
//  reset mid-stream overrides en/flush; in-flight stage op discarded, no flag write.
// TESTING
//  1 reset, PIPE=1, valid CMP (Funct 10101,Cond 1110), ALUFlags 0110 -> next cycle
//    ALUControl=001,NoWrite=1,CondEx=1; after following edge Flags=0110.
//  2 Flags Z=1; ADDEQ S=1 with ALUFlags 0000 -> CondEx=1, Flags->0000; then ADDEQ -> CondEx=0,
//    Flags unchanged.
//  3 ANDS (00001) with ALUFlags 1011 from Flags 0000 -> Flags=1000 (C,V preserved).
//  4 EXT_OPS=0: EOR (00010) -> Illegal=1,FlagW=00,NoWrite=1; ORR 11000 -> ALUControl=011.
//  5 en=0 for 3 cycles with new inputs -> stage/Flags hold; flush with en=0 -> CondEx=0 next.
//  6 TST S=0 (10000) -> Illegal=1; assert reset during valid SUBS -> Flags=0000, outputs 0.

Source files
------------

// File: rtl/alu_ctrl_unit.sv
// ALU control for the ARMv4 datapath: data-processing decode, optional execute-stage register,
// NZCV flag register and condition evaluation on the stored flags.
module alu_ctrl_unit #(
  parameter bit PIPE    = 1'b1,
  parameter bit EXT_OPS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       flush,
  input  logic       valid_i,
  input  logic       ALUOp,
  input  logic [4:0] Funct,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic [2:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic       CondEx,
  output logic       Illegal,
  output logic [3:0] Flags
);

  typedef struct packed {
    logic       vld;
    logic [2:0] ctrl;
    logic [1:0] flagw;
    logic       nowrite;
    logic       illegal;
    logic [3:0] cond;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  stage_t     dec;
  stage_t     st;
  logic [3:0] cmd;
  logic       s;
  logic       ext;
  logic       cond_true;
  logic       n, z, c, v;

  assign cmd = Funct[4:1];
  assign s   = Funct[0];

  always_comb begin
    dec         = BUBBLE;
    dec.vld     = valid_i;
    dec.cond    = Cond;
    ext         = 1'b0;
    if (ALUOp) begin
      unique case (cmd)
        4'b0100: begin dec.ctrl = 3'b000; dec.flagw = s ? 2'b11 : 2'b00; end
        4'b0010: begin dec.ctrl = 3'b001; dec.flagw = s ? 2'b11 : 2'b00; end
        4'b0000: begin dec.ctrl = 3'b010; dec.flagw = s ? 2'b10 : 2'b00; end
        4'b1100: begin dec.ctrl = 3'b011; dec.flagw = s ? 2'b10 : 2'b00; end
        4'b0001: begin dec.ctrl = 3'b100; dec.flagw = s ? 2'b10 : 2'b00; ext = 1'b1; end
        4'b1110: begin dec.ctrl = 3'b101; dec.flagw = s ? 2'b10 : 2'b00; ext = 1'b1; end
        4'b1101: begin dec.ctrl = 3'b110; dec.flagw = s ? 2'b10 : 2'b00; ext = 1'b1; end
        4'b1111: begin dec.ctrl = 3'b111; dec.flagw = s ? 2'b10 : 2'b00; ext = 1'b1; end
        4'b1010: begin dec.ctrl = 3'b001; dec.flagw = 2'b11; dec.nowrite = 1'b1; ext = 1'b1; end
        4'b1011: begin dec.ctrl = 3'b000; dec.flagw = 2'b11; dec.nowrite = 1'b1; ext = 1'b1; end
        4'b1000: begin dec.ctrl = 3'b010; dec.flagw = 2'b10; dec.nowrite = 1'b1; ext = 1'b1; end
        4'b1001: begin dec.ctrl = 3'b100; dec.flagw = 2'b10; dec.nowrite = 1'b1; ext = 1'b1; end
        default: dec.illegal = 1'b1;
      endcase
      // compare/test without S, or an extended op when they are disabled, is undecodable
      if ((cmd[3:2] == 2'b10 && !s) || (ext && !EXT_OPS))
        dec.illegal = 1'b1;
      if (dec.illegal) begin
        dec.ctrl    = 3'b000;
        dec.flagw   = 2'b00;
        dec.nowrite = 1'b1;
      end
    end
  end

  generate
    if (PIPE) begin : g_pipe
      always_ff @(posedge clk) begin
        if (reset)      st <= BUBBLE;
        else if (flush) st <= BUBBLE;
        else if (en)    st <= dec;
      end
    end else begin : g_comb
      assign st = dec;
    end
  endgenerate

  assign {n, z, c, v} = Flags;

  always_comb begin
    unique case (st.cond)
      4'b0000: cond_true = z;
      4'b0001: cond_true = ~z;
      4'b0010: cond_true = c;
      4'b0011: cond_true = ~c;
      4'b0100: cond_true = n;
      4'b0101: cond_true = ~n;
      4'b0110: cond_true = v;
      4'b0111: cond_true = ~v;
      4'b1000: cond_true = c & ~z;
      4'b1001: cond_true = ~c | z;
      4'b1010: cond_true = (n == v);
      4'b1011: cond_true = (n != v);
      4'b1100: cond_true = ~z & (n == v);
      4'b1101: cond_true = z | (n != v);
      default: cond_true = 1'b1;
    endcase
  end

  assign ALUControl = st.ctrl;
  assign FlagW      = st.flagw;
  assign NoWrite    = st.nowrite;
  assign Illegal    = st.vld & st.illegal;
  assign CondEx     = st.vld & cond_true;

  // no bypass: a flag update becomes visible to CondEx only after the edge that writes it
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else if (en && CondEx) begin
      if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed bench: pipelined full-op unit, pipelined base-op-only unit and a combinational unit share stimulus.
module tb_alu_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset, en, flush, valid_i, ALUOp;
  logic [4:0] Funct;
  logic [3:0] Cond, ALUFlags;

  logic [2:0] ctl_p, ctl_x, ctl_c;
  logic [1:0] fw_p, fw_x, fw_c;
  logic       nw_p, nw_x, nw_c;
  logic       ce_p, ce_x, ce_c;
  logic       il_p, il_x, il_c;
  logic [3:0] fl_p, fl_x, fl_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_unit #(.PIPE(1'b1), .EXT_OPS(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i), .ALUOp(ALUOp),
    .Funct(Funct), .Cond(Cond), .ALUFlags(ALUFlags), .ALUControl(ctl_p), .FlagW(fw_p),
    .NoWrite(nw_p), .CondEx(ce_p), .Illegal(il_p), .Flags(fl_p));

  alu_ctrl_unit #(.PIPE(1'b1), .EXT_OPS(1'b0)) dut_x (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i), .ALUOp(ALUOp),
    .Funct(Funct), .Cond(Cond), .ALUFlags(ALUFlags), .ALUControl(ctl_x), .FlagW(fw_x),
    .NoWrite(nw_x), .CondEx(ce_x), .Illegal(il_x), .Flags(fl_x));

  alu_ctrl_unit #(.PIPE(1'b0), .EXT_OPS(1'b1)) dut_c (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i), .ALUOp(ALUOp),
    .Funct(Funct), .Cond(Cond), .ALUFlags(ALUFlags), .ALUControl(ctl_c), .FlagW(fw_c),
    .NoWrite(nw_c), .CondEx(ce_c), .Illegal(il_c), .Flags(fl_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic v, input logic [4:0] f, input logic [3:0] c);
    valid_i = v;
    ALUOp   = 1'b1;
    Funct   = f;
    Cond    = c;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; flush = 1'b0; valid_i = 1'b0; ALUOp = 1'b0;
    Funct = '0; Cond = '0; ALUFlags = '0;
    tick(); tick();
    chk("rst_flags", fl_p, 4'b0000);
    chk("rst_ctl", {1'b0, ctl_p}, 4'h0);
    chk("rst_flagw", {2'b00, fw_p}, 4'h0);
    chk("rst_nowrite", {3'b000, nw_p}, 4'h0);
    chk("rst_condex", {3'b000, ce_p}, 4'h0);
    chk("rst_illegal", {3'b000, il_p}, 4'h0);
    reset = 1'b0;

    // CMP AL, one cycle through the stage, flags written at the following edge
    instr(1'b1, 5'b10101, 4'b1110); ALUFlags = 4'b0110;
    tick();
    chk("cmp_ctl", {1'b0, ctl_p}, 4'b0001);
    chk("cmp_nowrite", {3'b000, nw_p}, 4'h1);
    chk("cmp_condex", {3'b000, ce_p}, 4'h1);
    chk("cmp_flagw", {2'b00, fw_p}, 4'b0011);
    chk("cmp_flags_pre", fl_p, 4'b0000);
    valid_i = 1'b0;
    tick();
    chk("cmp_flags_post", fl_p, 4'b0110);
    chk("bubble_condex", {3'b000, ce_p}, 4'h0);

    // ADDSEQ twice: first clears Z, second then fails its condition
    instr(1'b1, 5'b01001, 4'b0000); ALUFlags = 4'b0000;
    tick();
    chk("addeq1_condex", {3'b000, ce_p}, 4'h1);
    tick();
    chk("addeq1_flags", fl_p, 4'b0000);
    chk("addeq2_condex", {3'b000, ce_p}, 4'h0);
    valid_i = 1'b0; ALUFlags = 4'b1111;
    tick();
    chk("addeq2_flags", fl_p, 4'b0000);

    // ANDS writes only N,Z
    instr(1'b1, 5'b00001, 4'b1110); ALUFlags = 4'b1011;
    tick();
    chk("ands_ctl", {1'b0, ctl_p}, 4'b0010);
    chk("ands_flagw", {2'b00, fw_p}, 4'b0010);
    valid_i = 1'b0;
    tick();
    chk("ands_flags", fl_p, 4'b1000);

    // LT/GE on N=1,V=0 using MOV
    instr(1'b1, 5'b11010, 4'b1011);
    tick();
    chk("mov_ctl", {1'b0, ctl_p}, 4'b0110);
    chk("lt_condex", {3'b000, ce_p}, 4'h1);
    instr(1'b1, 5'b11010, 4'b1010);
    tick();
    chk("ge_condex", {3'b000, ce_p}, 4'h0);

    // base-op-only unit rejects EOR; combinational unit decodes it at once
    instr(1'b1, 5'b00010, 4'b1110);
    #1;
    chk("comb_eor_ctl", {1'b0, ctl_c}, 4'b0100);
    chk("comb_eor_condex", {3'b000, ce_c}, 4'h1);
    tick();
    chk("x_eor_illegal", {3'b000, il_x}, 4'h1);
    chk("x_eor_flagw", {2'b00, fw_x}, 4'h0);
    chk("x_eor_nowrite", {3'b000, nw_x}, 4'h1);
    chk("x_eor_ctl", {1'b0, ctl_x}, 4'h0);
    chk("p_eor_ctl", {1'b0, ctl_p}, 4'b0100);
    chk("p_eor_illegal", {3'b000, il_p}, 4'h0);
    instr(1'b1, 5'b11000, 4'b1110);
    tick();
    chk("x_orr_ctl", {1'b0, ctl_x}, 4'b0011);
    chk("x_orr_illegal", {3'b000, il_x}, 4'h0);

    // stall with a flag-writing SUBS held in the stage
    instr(1'b1, 5'b00101, 4'b1110);
    tick();
    en = 1'b0; ALUFlags = 4'b0101;
    instr(1'b1, 5'b00001, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ctl", {1'b0, ctl_p}, 4'b0001);
      chk("stall_flags", fl_p, 4'b1000);
    end
    flush = 1'b1;
    tick();
    chk("flush_condex", {3'b000, ce_p}, 4'h0);
    chk("flush_flagw", {2'b00, fw_p}, 4'h0);
    chk("flush_flags", fl_p, 4'b1000);
    flush = 1'b0; en = 1'b1;

    // TST without S is illegal
    instr(1'b1, 5'b10000, 4'b1110); ALUFlags = 4'b0110;
    tick();
    chk("tst_illegal", {3'b000, il_p}, 4'h1);
    chk("tst_nowrite", {3'b000, nw_p}, 4'h1);
    chk("tst_ctl", {1'b0, ctl_p}, 4'h0);

    // reset overrides a pending SUBS flag write
    instr(1'b1, 5'b00101, 4'b1110);
    tick();
    chk("subs_condex", {3'b000, ce_p}, 4'h1);
    chk("subs_flags_pre", fl_p, 4'b1000);
    reset = 1'b1;
    tick();
    chk("mid_rst_flags", fl_p, 4'b0000);
    chk("mid_rst_ctl", {1'b0, ctl_p}, 4'h0);
    chk("mid_rst_flagw", {2'b00, fw_p}, 4'h0);
    chk("mid_rst_condex", {3'b000, ce_p}, 4'h0);
    chk("mid_rst_nowrite", {3'b000, nw_p}, 4'h0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
